// File: rtl/drone_dispatch_sched.sv
// drone_dispatch_sched: two-floor drone delivery scheduler with round-robin pick and flight/pickup timeout
module drone_dispatch_sched #(
  parameter int TIMEOUT = 200
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic [1:0] FS,
  input  logic [1:0] Call,
  output logic [1:0] Floor,
  output logic       busy,
  output logic [1:0] pending,
  output logic [1:0] cur,
  output logic       timeout_err,
  output logic [7:0] served_cnt
);
  typedef enum logic [2:0] {IDLE, DISPATCH, FLY, WAIT_CALL, DONE} state_t;
  state_t state_q, state_d;
  logic [7:0] cnt_q, cnt_d, served_q, served_d;
  logic [1:0] pending_q, pending_d, cur_q, cur_d, last_q, last_d, floor_q, floor_d, sel, clr;
  logic busy_q, busy_d, tout_q, tout_d, hit, expire;
  assign Floor = floor_q;
  assign busy = busy_q;
  assign pending = pending_q;
  assign cur = cur_q;
  assign timeout_err = tout_q;
  assign served_cnt = served_q;
  // next-state logic; a same-cycle request beats the clear of its floor
  always_comb begin
    sel = (pending_q == 2'b11) ? ~last_q : pending_q;
    hit = (state_q == FLY) ? (FS == cur_q) : |(Call & cur_q);
    expire = cnt_q == 8'(TIMEOUT - 1);
    clr = '0;
    state_d = state_q;
    cnt_d = '0;
    cur_d = cur_q;
    last_d = last_q;
    served_d = served_q;
    tout_d = 1'b0;
    case (state_q)
      IDLE: if (|pending_q) begin
        clr = sel;
        cur_d = sel;
        state_d = DISPATCH;
      end
      DISPATCH: state_d = FLY;
      FLY, WAIT_CALL: if (hit) state_d = (state_q == FLY) ? WAIT_CALL : DONE;
        else if (expire) begin
          tout_d = 1'b1;
          last_d = cur_q;
          cur_d = '0;
          state_d = IDLE;
        end else cnt_d = cnt_q + 8'd1;
      DONE: begin
        served_d = served_q + 8'd1;
        last_d = cur_q;
        cur_d = '0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    pending_d = req | (pending_q & ~clr);
    floor_d = (state_d == DISPATCH) ? cur_d : 2'b00;
    busy_d = state_d != IDLE;
  end
  // state and registered outputs; reset drops any concurrent request
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q <= '0;
      served_q <= '0;
      pending_q <= '0;
      cur_q <= '0;
      last_q <= 2'b10;
      floor_q <= '0;
      busy_q <= 1'b0;
      tout_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      served_q <= served_d;
      pending_q <= pending_d;
      cur_q <= cur_d;
      last_q <= last_d;
      floor_q <= floor_d;
      busy_q <= busy_d;
      tout_q <= tout_d;
    end
  end
endmodule

// File: tb/tb_drone_dispatch_sched.sv
// tb_drone_dispatch_sched: directed checks of dispatch, round-robin, timeout, reset and counter wrap
module tb_drone_dispatch_sched;
  localparam int TO = 10;
  logic clk = 1'b0, rst = 1'b1;
  logic [1:0] req = '0, fs = '0, call = '0;
  logic [1:0] floor, pending, cur;
  logic busy, timeout_err;
  logic [7:0] served_cnt;
  int checks = 0, failures = 0;
  drone_dispatch_sched #(.TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .req(req), .FS(fs), .Call(call),
    .Floor(floor), .busy(busy), .pending(pending), .cur(cur),
    .timeout_err(timeout_err), .served_cnt(served_cnt)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic finish_fly(input logic [1:0] f);
    fs = f;
    tick();
    chk("to_wait_busy", 32'(busy), 1);
    fs = '0;
    call = f;
    tick();
    chk("done_floor", 32'(floor), 0);
    call = '0;
    tick();
    chk("idle_busy", 32'(busy), 0);
    chk("idle_cur", 32'(cur), 0);
  endtask
  task automatic start(input logic [1:0] r);
    req = r;
    tick();
    req = '0;
    tick();
  endtask
  initial begin
    tick();
    tick();
    chk("rst_floor", 32'(floor), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_pending", 32'(pending), 0);
    chk("rst_cur", 32'(cur), 0);
    chk("rst_tout", 32'(timeout_err), 0);
    chk("rst_served", 32'(served_cnt), 0);
    rst = 1'b0;
    req = 2'b01;
    tick();
    chk("t1_pending", 32'(pending), 1);
    chk("t1_floor_early", 32'(floor), 0);
    req = '0;
    tick();
    chk("t1_floor", 32'(floor), 1);
    chk("t1_cur", 32'(cur), 1);
    chk("t1_clr", 32'(pending), 0);
    tick();
    chk("t1_floor_off", 32'(floor), 0);
    tick();
    tick();
    finish_fly(2'b01);
    chk("t1_served", 32'(served_cnt), 1);
    chk("t1_pending_end", 32'(pending), 0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    start(2'b11);
    chk("t2_first", 32'(floor), 1);
    chk("t2_pend", 32'(pending), 2);
    tick();
    finish_fly(2'b01);
    tick();
    chk("t2_second", 32'(floor), 2);
    tick();
    finish_fly(2'b10);
    chk("t2_served", 32'(served_cnt), 2);
    start(2'b11);
    chk("t2_rr_first", 32'(floor), 1);
    tick();
    finish_fly(2'b01);
    tick();
    chk("t2_rr_second", 32'(floor), 2);
    tick();
    finish_fly(2'b10);
    chk("t2_served4", 32'(served_cnt), 4);
    start(2'b10);
    tick();
    for (int i = 1; i < TO; i++) begin
      tick();
      chk("t3_no_tout", 32'(timeout_err), 0);
    end
    tick();
    chk("t3_tout", 32'(timeout_err), 1);
    chk("t3_busy", 32'(busy), 0);
    chk("t3_pending", 32'(pending), 0);
    chk("t3_served", 32'(served_cnt), 4);
    tick();
    chk("t3_tout_pulse", 32'(timeout_err), 0);
    start(2'b01);
    tick();
    for (int i = 1; i < TO; i++) tick();
    fs = 2'b01;
    tick();
    fs = '0;
    chk("t4_exit_wins_tout", 32'(timeout_err), 0);
    chk("t4_exit_wins_busy", 32'(busy), 1);
    call = 2'b01;
    tick();
    call = '0;
    tick();
    chk("t4_served", 32'(served_cnt), 5);
    start(2'b01);
    tick();
    req = 2'b01;
    fs = 2'b10;
    call = 2'b10;
    tick();
    req = '0;
    chk("t5_pending", 32'(pending), 1);
    chk("t5_busy", 32'(busy), 1);
    tick();
    chk("t5_still_fly_pending", 32'(pending), 1);
    fs = '0;
    call = '0;
    call = 2'b01;
    tick();
    call = '0;
    chk("t5_call_ignored", 32'(served_cnt), 5);
    finish_fly(2'b01);
    chk("t5_served", 32'(served_cnt), 6);
    tick();
    chk("t5_redispatch", 32'(floor), 1);
    tick();
    finish_fly(2'b01);
    chk("t5_served2", 32'(served_cnt), 7);
    start(2'b10);
    tick();
    fs = 2'b10;
    tick();
    fs = '0;
    rst = 1'b1;
    req = 2'b10;
    tick();
    chk("t6_floor", 32'(floor), 0);
    chk("t6_busy", 32'(busy), 0);
    chk("t6_pending", 32'(pending), 0);
    chk("t6_cur", 32'(cur), 0);
    chk("t6_tout", 32'(timeout_err), 0);
    chk("t6_served", 32'(served_cnt), 0);
    rst = 1'b0;
    req = '0;
    tick();
    chk("t6_pending_after", 32'(pending), 0);
    chk("t6_busy_after", 32'(busy), 0);
    for (int i = 0; i < 256; i++) begin
      start(2'b01);
      tick();
      finish_fly(2'b01);
      if (i == 254) chk("t7_served255", 32'(served_cnt), 255);
    end
    chk("t7_wrap", 32'(served_cnt), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/drone_dispatch_sched.md
DRONE_DISPATCH_SCHED -- requirements
Module: drone_dispatch_sched

Interface
REQ-001 Parameter TIMEOUT, default 200, cycles allowed in FLY or WAIT_CALL before abort; legal range 2..255.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 req  input  2  delivery request, one bit per floor (bit0 = floor 1, bit1 = floor 2); any high bit sampled on a clk edge registers a request.
REQ-005 FS  input  2  floor sensor from drone; one-hot floor at which the drone currently sits, 00 = none.
REQ-006 Call  input  2  customer pickup confirm per floor.
REQ-007 Floor  output  2  one-hot dispatch command to Drone_delivery, 00 = no command.
REQ-008 busy  output  1  high in any state other than IDLE.
REQ-009 pending  output  2  registered outstanding-request mask.
REQ-010 cur  output  2  one-hot floor being served, 00 in IDLE.
REQ-011 timeout_err  output  1  one-cycle abort pulse.
REQ-012 served_cnt  output  8  count of completed deliveries.

Function
REQ-013 States SHALL be IDLE, DISPATCH, FLY, WAIT_CALL, DONE; all outputs SHALL be registered or decoded from registered state only.
REQ-014 pending SHALL be updated each edge as (pending | req) & ~clr, except a req bit and a clr bit for the same floor in the same cycle SHALL leave that bit set (request wins).
REQ-015 IDLE: if pending != 00, select a floor, latch it into cur, assert clr for it, go to DISPATCH; else stay.
REQ-016 Selection: single pending bit -> that floor; both pending -> the floor not equal to last_served (round-robin).
REQ-017 DISPATCH lasts exactly one cycle with Floor = cur; Floor SHALL be 00 in every other state; next state FLY, timeout counter cleared.
REQ-018 FLY: FS == cur -> WAIT_CALL, counter cleared; FS showing the other floor SHALL be ignored.
REQ-019 WAIT_CALL: (Call & cur) != 0 -> DONE; Call for the other floor SHALL be ignored and SHALL NOT set pending.
REQ-020 DONE lasts one cycle: served_cnt += 1 (8-bit wrap 255 -> 0), last_served <= cur, next IDLE with cur = 00.
REQ-021 Timeout: counter increments every cycle in FLY and WAIT_CALL; on reaching TIMEOUT-1 without the exit condition, timeout_err SHALL pulse for the next cycle, the request SHALL be dropped (not re-queued), last_served <= cur, served_cnt unchanged, next IDLE.
REQ-022 Latency: req sampled at edge k -> pending set after edge k -> Floor asserted in the cycle after edge k+1 when IDLE.
REQ-023 A req for the floor in service SHALL set pending and be served after the current delivery completes.
REQ-024 FS/Call exit condition and timeout in the same cycle: exit condition SHALL win; no timeout_err.

Reset
REQ-025 rst high at an edge SHALL force state IDLE, Floor 00, cur 00, pending 00, busy 0, timeout_err 0, served_cnt 0, counter 0, last_served = floor 2 (so floor 1 wins first tie), regardless of current state.
REQ-026 req asserted in the same cycle as rst SHALL be discarded.
REQ-027 Reset mid-delivery SHALL abandon the delivery with no timeout_err and no served_cnt change.

Verification
REQ-028 req=01 one cycle; FS=01 after 3 cycles; Call=01 next -> Floor=01 for exactly one cycle 2 cycles after req, DONE then IDLE, served_cnt=1, pending=00.
REQ-029 req=11 one cycle; complete floor 1 then floor 2 via FS/Call -> Floor=01 first, later Floor=10, served_cnt=2; repeat req=11 -> floor 1 served first again only if last_served=2.
REQ-030 req=10, never drive FS -> timeout_err pulse exactly TIMEOUT cycles after entering FLY, pending=00, served_cnt unchanged, state IDLE.
REQ-031 During FLY for floor 1 pulse req=01 and drive FS=10, Call=10 -> no state change, pending=01; after completion floor 1 re-dispatched.
REQ-032 rst asserted in WAIT_CALL with req=10 same cycle -> all outputs at reset values next cycle, pending=00.
REQ-033 256 completed deliveries -> served_cnt wraps to 0.
